// File: rtl/mod_74x161_chain_if.sv
// Bus interface for the cascaded 74x161 counter chain.
// The master side drives load/enable/data; the slave side (the counter)
// returns the count, the final ripple carry and the per-stage carries.
//   load_n   : synchronous parallel load, active-low
//   enp      : count enable P, shared by every stage
//   ent      : count enable T into stage 0
//   d        : parallel load data, bit 0 = LSB of stage 0
//   q        : counter value, bit 0 = LSB
//   rco      : ripple carry out of the last stage
//   rco_stg  : per-stage ripple carry, bit k = stage k
`timescale 1ns/1ps
interface mod_74x161_chain_if #(
  parameter int STAGES = 2
);
  logic                  load_n;
  logic                  enp;
  logic                  ent;
  logic [4*STAGES-1:0]   d;
  logic [4*STAGES-1:0]   q;
  logic                  rco;
  logic [STAGES-1:0]     rco_stg;

  modport master (
    output load_n, enp, ent, d,
    input  q, rco, rco_stg
  );

  modport slave (
    input  load_n, enp, ent, d,
    output q, rco, rco_stg
  );
endinterface

// File: rtl/mod_74x161_chain.sv
// Cascaded 74x161 synchronous 4-bit binary counters, wired as on a board:
// enp is shared, stage 0 takes ent from the bus, stage k takes ent from
// the ripple carry of stage k-1. Feeds the downstream AND-array decode.
// Ports:
//   clk    : counter clock, all synchronous actions on the rising edge
//   rst_n  : asynchronous active-low clear (CLR_N)
//   bus    : mod_74x161_chain_if slave modport (load_n, enp, ent, d, q,
//            rco, rco_stg)
// Optional feature macro: MOD_74X161_CHAIN_TPD_EN
//   Defined   : simulation delay model, q follows TPD_CLK after a clock
//               update and TPD_CLR after clear; carries follow TPD_CLK.
//   Undefined : zero-delay outputs (the synthesizable build).
`timescale 1ns/1ps
module mod_74x161_chain #(
  parameter int STAGES  = 2,
  parameter int TPD_CLK = 15,
  parameter int TPD_CLR = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_74x161_chain_if.slave   bus
);

  localparam int W = 4 * STAGES;

  if (STAGES < 1 || STAGES > 8 || TPD_CLK < 0 || TPD_CLR < 0) begin : g_bad_param
    $error("mod_74x161_chain: STAGES must be 1..8 and delays non-negative");
  end

  logic [W-1:0]      q_r;
  logic [STAGES-1:0] ent_stg;
  logic [STAGES-1:0] rco_c;

  // Carry chain: each stage's ent is the previous stage's rco, so a low
  // ent into stage 0 kills every downstream enable and carry.
  always_comb begin
    logic carry;
    carry   = bus.ent;
    ent_stg = '0;
    rco_c   = '0;
    for (int k = 0; k < STAGES; k++) begin
      ent_stg[k] = carry;
      rco_c[k]   = carry & (q_r[4*k +: 4] == 4'hF);
      carry      = rco_c[k];
    end
  end

  // Load overrides both enables; otherwise each stage counts on enp & ent_k.
  // The chain is evaluated on pre-edge q, which is what makes the stages
  // together behave as one wide binary counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (!bus.load_n) begin
      q_r <= bus.d;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.enp && ent_stg[k]) begin
          q_r[4*k +: 4] <= q_r[4*k +: 4] + 4'd1;
        end
      end
    end
  end

`ifdef MOD_74X161_CHAIN_TPD_EN
  // Transport-style delayed copy: the old value stays visible through the
  // delay window, so no X is ever driven. A change seen while rst_n is low
  // can only be the clear, which uses the clear-to-output delay.
  logic [W-1:0] q_dly;

  initial q_dly = '0;

  always @(q_r) begin
    if (!rst_n) begin
      q_dly <= #(TPD_CLR) q_r;
    end else begin
      q_dly <= #(TPD_CLK) q_r;
    end
  end

  assign bus.q                 = q_dly;
  assign #(TPD_CLK) bus.rco_stg = rco_c;
  assign #(TPD_CLK) bus.rco     = rco_c[STAGES-1];
`else
  assign bus.q       = q_r;
  assign bus.rco_stg = rco_c;
  assign bus.rco     = rco_c[STAGES-1];
`endif

endmodule

// File: tb/tb_mod_74x161_chain.sv
`timescale 1ns/1ps
module tb_mod_74x161_chain;

  localparam int STAGES = 2;
  localparam int W      = 4 * STAGES;
  localparam int unsigned MOD = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mod_74x161_chain_if #(.STAGES(STAGES)) bus ();

  mod_74x161_chain #(.STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned m     = 0;   // reference count value

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stage k carries exactly when ent is high and the low 4*(k+1) bits of the
  // whole count are all ones.
  function automatic logic [STAGES-1:0] exp_stg(input int unsigned v, input logic e);
    logic [STAGES-1:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) begin
      int unsigned md;
      md   = 1 << (4 * (k + 1));
      r[k] = e && ((v % md) == md - 1);
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [STAGES-1:0] s;
    s = exp_stg(m, bus.ent);
    chk({tag, "_q"},   bus.q,       m);
    chk({tag, "_rco"}, bus.rco,     s[STAGES-1]);
    chk({tag, "_stg"}, bus.rco_stg, s);
  endtask

  task automatic drive(input logic l, input logic p, input logic t, input logic [W-1:0] dv);
    bus.load_n = l;
    bus.enp    = p;
    bus.ent    = t;
    bus.d      = dv;
  endtask

  // One rising edge with the model updated from the sampled inputs, then
  // return at the following falling edge for checking.
  task automatic edge_step();
    @(posedge clk);
    if (rst_n) begin
      if (!bus.load_n)               m = bus.d;
      else if (bus.enp && bus.ent)   m = (m + 1) % MOD;
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    m = 0;
    chk("rst_q",   bus.q,       8'h00);
    chk("rst_rco", bus.rco,     1'b0);
    chk("rst_stg", bus.rco_stg, 2'b00);

    // Release just after a rising edge: that edge saw clear, nothing happens.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_q", bus.q, 8'h00);
    edge_step();
    chk("rel_load", bus.q, 8'hA5);

    drive(1'b0, 1'b0, 1'b0, 8'h3C);
    edge_step();
    chk("load_3c", bus.q, 8'h3C);

    drive(1'b0, 1'b0, 1'b0, 8'h0E);
    edge_step();
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    #1 chk("cnt_0e_stg0", bus.rco_stg[0], 1'b0);
    edge_step();
    chk("cnt_0f", bus.q, 8'h0F);
    chk("cnt_0f_stg0", bus.rco_stg[0], 1'b1);
    chk("cnt_0f_rco", bus.rco, 1'b0);
    edge_step();
    chk("cnt_10", bus.q, 8'h10);
    chk("cnt_10_stg0", bus.rco_stg[0], 1'b0);
    edge_step();
    chk("cnt_11", bus.q, 8'h11);

    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    edge_step();
    chk("tc_q", bus.q, 8'hFF);
    chk("tc_rco", bus.rco, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    edge_step();
    edge_step();
    chk("tc_hold_q", bus.q, 8'hFF);
    chk("tc_hold_rco", bus.rco, 1'b1);
    bus.ent = 1'b0;
    #1 chk("tc_ent0_rco", bus.rco, 1'b0);
    chk("tc_ent0_stg", bus.rco_stg, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    edge_step();
    chk("wrap_q", bus.q, 8'h00);
    chk("wrap_rco", bus.rco, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 8'h40);
    edge_step();
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    edge_step();
    chk("cnt_41", bus.q, 8'h41);
    drive(1'b0, 1'b1, 1'b1, 8'h07);
    edge_step();
    chk("load_prio", bus.q, 8'h07);
    #2 rst_n = 1'b0;
    #1 chk("aclr_q", bus.q, 8'h00);
    m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all("aclr_post");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) != 0), W'($urandom));
      #1 check_all("rnd_comb");
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1 m = 0;
        check_all("rnd_aclr");
        rst_n = 1'b1;
      end
      edge_step();
      check_all("rnd_edge");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
